instr_encoder: RTL and testbench
================================

# instr_encoder

RV32I instruction encoder and program loader; the inverse of the decode stage's control unit. It accepts decoded instruction descriptors (kind, operation, register indices, immediate) over a valid/ready handshake and packs each into a 32-bit RV32I word. It writes the words sequentially into instruction memory through a write handshake. It is used by the test harness and boot path to build programs in IMEM without an external assembler.

## Interface
- ADDR_W, 10, IMEM word-address width.
- BASE_ADDR, 0, first word address written after start.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- Start_i  in  1  begin a load at BASE_ADDR; ignored unless IDLE or DONE.
- Valid_i  in  1  descriptor valid.
- Ready_o  out  1  encoder can accept a descriptor.
- Kind_i  in  4  instruction class: R, I, LD, S, B, JAL, JALR, LUI, AUIPC.
- Op_i  in  4  ALU op (R/I), size+sign (LD/S), or comparator op (B); ignored for others.
- Rd_i, Rs1_i, Rs2_i  in  5 each  register indices.
- Imm_i  in  32  byte-offset or value immediate, sign-extended form.
- Last_i  in  1  final descriptor of program.
- Imem_we_o  out  1  write request.
- Imem_ready_i  in  1  memory accepts write this cycle.
- Imem_addr_o  out  ADDR_W  word address.
- Imem_data_o  out  32  encoded word.
- Done_o  out  1  load complete.
- Full_o  out  1  last address written.
- Error_o  out  1  sticky: an illegal descriptor was seen.
- Count_o  out  ADDR_W+1  words written since start.

## Operation
- FSM states:
  - IDLE: Start_i → ACCEPT; address := BASE_ADDR; Count_o, Error_o, Full_o := 0.
  - ACCEPT: Ready_o = 1. Valid_i & Ready_o captures the encoded word and Last_i → WRITE.
  - WRITE: Imem_we_o = 1 with address and data held stable until Imem_ready_i.
    - On the write handshake: address+1 and Count_o+1.
    - Next state: DONE if the captured Last_i was set or the address was all-ones (also sets Full_o); else ACCEPT.
  - DONE: Done_o = 1. Start_i → ACCEPT with the same clears as from IDLE.
- Ready_o is 0 in IDLE, WRITE and DONE. Valid_i in those states is not consumed.
- Encoding follows RV32I:
  - R: SUB and SRA set funct7 = 0100000; all other R ops use 0000000.
  - I shifts: shamt = Imm_i[4:0]; SRAI sets funct7 = 0100000.
  - S/B: immediate is split per the ISA.
  - JAL: 21-bit offset.
  - LUI/AUIPC: word = Imm_i[31:12] in the upper field.
- Illegal descriptor: unknown Kind_i or invalid Op_i for the kind. The word is replaced by NOP 0x00000013, Error_o is set, and the write still occurs.
- Address wraps only via restart; no writes beyond the all-ones address.
- Start_i while in ACCEPT or WRITE is ignored.

## Timing
- Reset values: all outputs 0, state IDLE. Reset mid-WRITE deasserts Imem_we_o immediately; the pending word is dropped.
- Latency: a descriptor accepted at edge N gives Imem_we_o high from N+1.
- Throughput: at most one word per 2 cycles (ACCEPT + WRITE with Imem_ready_i already high).
- Imem_we_o stays high across stall cycles; data and address do not change while stalled.
- Done_o is high from the edge after the final write handshake until Start_i is accepted.

## Configuration
- INSTR_ENCODER_RANGE_CHECK_EN defined: the following are illegal (NOP written, Error_o set):
  - I/LD/S/JALR immediates outside signed 12-bit.
  - B immediates outside signed 13-bit or odd.
  - JAL immediates outside signed 21-bit or odd.
  - Shift Imm_i above 31.
  - LUI/AUIPC with Imm_i[11:0] ≠ 0.
- Undefined: immediates are truncated silently to the field width. Only Kind/Op checks raise Error_o.

## Structure
- Shared package encoder_pkg holds:
  - Kind enum.
  - ALU / size / comparator op codes (same values the decode stage produces).
  - Opcode, funct3 and funct7 constants.
  - NOP constant.
- Sub-module instr_field_packer: combinational descriptor → {word, illegal}, including range checks. The top holds the FSM, counters and the output register.

## Test plan
- Start, then R SUB rd=3 rs1=1 rs2=2 with Last=1 → addr 0 gets 0x402081B3; Done_o=1, Count_o=1.
- ADDI rd=1 rs1=0 imm=5, then S SW rs1=1 rs2=2 imm=8 → 0x00500093 at 0 and 0x0020A423 at 1.
- LUI rd=5 imm=0x12345000 with Imem_ready_i low for 3 cycles → Imem_we_o held 4 cycles, data 0x123452B7 stable throughout.
- B BEQ imm=3 (range check on) → 0x00000013 written and Error_o sticky through DONE. Same with the macro off → no error.
- ADDR_W=2 with 5 descriptors, none Last → 4 writes, Full_o=1, Done_o=1, 5th Valid_i never accepted.
- rst_i pulsed while in WRITE → Imem_we_o drops asynchronously, all outputs 0, state IDLE.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encoding vocabulary for instr_encoder: descriptor kinds, op codes,
// opcode/funct constants and the FSM state type.
package encoder_pkg;

  typedef enum logic [3:0] {
    KIND_R     = 4'd0,
    KIND_I     = 4'd1,
    KIND_LD    = 4'd2,
    KIND_S     = 4'd3,
    KIND_B     = 4'd4,
    KIND_JAL   = 4'd5,
    KIND_JALR  = 4'd6,
    KIND_LUI   = 4'd7,
    KIND_AUIPC = 4'd8
  } kind_e;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  // Size and comparator codes equal their funct3 so they drop straight into the word.
  localparam logic [3:0] SZ_B  = 4'd0;
  localparam logic [3:0] SZ_H  = 4'd1;
  localparam logic [3:0] SZ_W  = 4'd2;
  localparam logic [3:0] SZ_BU = 4'd4;
  localparam logic [3:0] SZ_HU = 4'd5;

  localparam logic [3:0] CMP_EQ  = 4'd0;
  localparam logic [3:0] CMP_NE  = 4'd1;
  localparam logic [3:0] CMP_LT  = 4'd4;
  localparam logic [3:0] CMP_GE  = 4'd5;
  localparam logic [3:0] CMP_LTU = 4'd6;
  localparam logic [3:0] CMP_GEU = 4'd7;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } enc_state_e;

  function automatic logic [2:0] alu_funct3(input logic [3:0] op);
    logic [2:0] f;
    case (op)
      ALU_ADD, ALU_SUB: f = 3'b000;
      ALU_SLL:          f = 3'b001;
      ALU_SLT:          f = 3'b010;
      ALU_SLTU:         f = 3'b011;
      ALU_XOR:          f = 3'b100;
      ALU_SRL, ALU_SRA: f = 3'b101;
      ALU_OR:           f = 3'b110;
      default:          f = 3'b111;
    endcase
    return f;
  endfunction

  function automatic logic [6:0] alu_funct7(input logic [3:0] op);
    return ((op == ALU_SUB) || (op == ALU_SRA)) ? F7_ALT : F7_BASE;
  endfunction

  // True when v survives truncation to a w-bit two's-complement field.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned w);
    logic [31:0] t;
    t = 32'($signed(v) >>> (w - 1));
    return (t == '0) || (t == '1);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Descriptor, IMEM-write and status bundle of instr_encoder; slave is the encoder side.
interface instr_encoder_if #(parameter int ADDR_W = 10);
  import encoder_pkg::*;

  // Both handshakes complete on a rising edge where the source's valid (valid_i /
  // imem_we_o) and the sink's ready (ready_o / imem_ready_i) are high together;
  // the source holds its payload unchanged until that edge.
  logic              start_i;
  logic              valid_i;
  logic              ready_o;
  logic [3:0]        kind_i;
  logic [3:0]        op_i;
  logic [4:0]        rd_i;
  logic [4:0]        rs1_i;
  logic [4:0]        rs2_i;
  logic [31:0]       imm_i;
  logic              last_i;
  logic              imem_we_o;
  logic              imem_ready_i;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_data_o;
  logic              done_o;
  logic              full_o;
  logic              error_o;
  logic [ADDR_W:0]   count_o;
  enc_state_e        state_o;

  modport slave (
    input  start_i, valid_i, kind_i, op_i, rd_i, rs1_i, rs2_i, imm_i, last_i, imem_ready_i,
    output ready_o, imem_we_o, imem_addr_o, imem_data_o, done_o, full_o, error_o, count_o,
    state_o
  );

  modport master (
    output start_i, valid_i, kind_i, op_i, rd_i, rs1_i, rs2_i, imm_i, last_i, imem_ready_i,
    input  ready_o, imem_we_o, imem_addr_o, imem_data_o, done_o, full_o, error_o, count_o,
    state_o
  );

endinterface

// File: rtl/instr_encoder_packer.sv
// instr_field_packer: combinational descriptor -> RV32I word, NOP-substituted when illegal.
// Immediate range checks exist only with INSTR_ENCODER_RANGE_CHECK_EN defined.
module instr_field_packer
  import encoder_pkg::*;
(
  input  logic [3:0]  kind_i,
  input  logic [3:0]  op_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  logic [31:0] raw;
  logic        bad_op;
  logic        bad_range;
  logic        is_shift;
  logic [2:0]  f3;
  logic [6:0]  f7;

  always_comb begin
    raw       = NOP;
    bad_op    = 1'b0;
    bad_range = 1'b0;
    is_shift  = (op_i == ALU_SLL) || (op_i == ALU_SRL) || (op_i == ALU_SRA);
    f3        = alu_funct3(op_i);
    f7        = alu_funct7(op_i);

    case (kind_i)
      KIND_R: begin
        bad_op = (op_i > ALU_AND);
        raw    = {f7, rs2_i, rs1_i, f3, rd_i, OPC_OP};
      end
      KIND_I: begin
        bad_op = (op_i > ALU_AND) || (op_i == ALU_SUB);
        if (is_shift) raw = {f7, imm_i[4:0], rs1_i, f3, rd_i, OPC_OPIMM};
        else          raw = {imm_i[11:0], rs1_i, f3, rd_i, OPC_OPIMM};
      end
      KIND_LD: begin
        bad_op = !(op_i inside {SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU});
        raw    = {imm_i[11:0], rs1_i, op_i[2:0], rd_i, OPC_LOAD};
      end
      KIND_S: begin
        bad_op = !(op_i inside {SZ_B, SZ_H, SZ_W});
        raw    = {imm_i[11:5], rs2_i, rs1_i, op_i[2:0], imm_i[4:0], OPC_STORE};
      end
      KIND_B: begin
        bad_op = !(op_i inside {CMP_EQ, CMP_NE, CMP_LT, CMP_GE, CMP_LTU, CMP_GEU});
        raw    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, op_i[2:0], imm_i[4:1], imm_i[11],
                  OPC_BRANCH};
      end
      KIND_JAL:   raw = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OPC_JAL};
      KIND_JALR:  raw = {imm_i[11:0], rs1_i, 3'b000, rd_i, OPC_JALR};
      KIND_LUI:   raw = {imm_i[31:12], rd_i, OPC_LUI};
      KIND_AUIPC: raw = {imm_i[31:12], rd_i, OPC_AUIPC};
      default:    bad_op = 1'b1;
    endcase

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    case (kind_i)
      KIND_I:                     bad_range = is_shift ? (|imm_i[31:5]) : !fits_signed(imm_i, 12);
      KIND_LD, KIND_S, KIND_JALR: bad_range = !fits_signed(imm_i, 12);
      KIND_B:                     bad_range = !fits_signed(imm_i, 13) || imm_i[0];
      KIND_JAL:                   bad_range = !fits_signed(imm_i, 21) || imm_i[0];
      KIND_LUI, KIND_AUIPC:       bad_range = |imm_i[11:0];
      default:                    bad_range = 1'b0;
    endcase
`endif

    illegal_o = bad_op | bad_range;
    word_o    = illegal_o ? NOP : raw;
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts descriptors, encodes them and writes them to IMEM in sequence.
// Build with INSTR_ENCODER_RANGE_CHECK_EN to reject out-of-range immediates.
module instr_encoder
  import encoder_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input logic            clk_i,
  input logic            rst_i,
  instr_encoder_if.slave bus
);

  enc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       data_q, data_d;
  logic              last_q, last_d;
  logic              error_q, error_d;
  logic              full_q, full_d;
  logic              ready_q, we_q, done_q;
  logic [31:0]       pk_word;
  logic              pk_illegal;

  instr_field_packer u_packer (
    .kind_i    (bus.kind_i),
    .op_i      (bus.op_i),
    .rd_i      (bus.rd_i),
    .rs1_i     (bus.rs1_i),
    .rs2_i     (bus.rs2_i),
    .imm_i     (bus.imm_i),
    .word_o    (pk_word),
    .illegal_o (pk_illegal)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    data_d  = data_q;
    last_d  = last_q;
    error_d = error_q;
    full_d  = full_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start_i) begin
          state_d = S_ACCEPT;
          addr_d  = ADDR_W'(BASE_ADDR);
          count_d = '0;
          error_d = 1'b0;
          full_d  = 1'b0;
        end
      end
      S_ACCEPT: begin
        if (bus.valid_i) begin
          data_d  = pk_word;
          last_d  = bus.last_i;
          error_d = error_q | pk_illegal;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (bus.imem_ready_i) begin
          addr_d  = addr_q + ADDR_W'(1);
          count_d = count_q + (ADDR_W + 1)'(1);
          // The all-ones address is the last slot; the wrapped address is never written.
          if (addr_q == '1) full_d = 1'b1;
          state_d = (last_q || (addr_q == '1)) ? S_DONE : S_ACCEPT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      error_q <= 1'b0;
      full_q  <= 1'b0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      data_q  <= data_d;
      last_q  <= last_d;
      error_q <= error_d;
      full_q  <= full_d;
      ready_q <= (state_d == S_ACCEPT);
      we_q    <= (state_d == S_WRITE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign bus.ready_o     = ready_q;
  assign bus.imem_we_o   = we_q;
  assign bus.imem_addr_o = addr_q;
  assign bus.imem_data_o = data_q;
  assign bus.done_o      = done_q;
  assign bus.full_o      = full_q;
  assign bus.error_o     = error_q;
  assign bus.count_o     = count_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed steps plus random descriptors against an ISA-level model,
// with a small ADDR_W=2 instance for the full-memory case.
module tb_instr_encoder;
  import encoder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(10)) bus ();
  instr_encoder_if #(.ADDR_W(2))  bus_s ();

  instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) u_dut   (.clk_i(clk), .rst_i(rst), .bus(bus));
  instr_encoder #(.ADDR_W(2),  .BASE_ADDR(0)) u_small (.clk_i(clk), .rst_i(rst), .bus(bus_s));

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  int          exp_addr;
  int          exp_count;
  bit          exp_err;
  int          alu_f3[10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // ISA field layout: funct7 | rs2 | rs1 | funct3 | rd | opcode.
  function automatic logic [31:0] fmt(input int f7, input int r2, input int r1, input int f3,
                                      input int rdf, input int opc);
    logic [31:0] r;
    r = 32'(opc & 127);
    r = r | (32'(rdf & 31) << 7);
    r = r | (32'(f3 & 7) << 12);
    r = r | (32'(r1 & 31) << 15);
    r = r | (32'(r2 & 31) << 20);
    r = r | (32'(f7 & 127) << 25);
    return r;
  endfunction

  function automatic int bits(input logic [31:0] v, input int lo, input int n);
    return int'((v >> lo) & ((32'd1 << n) - 32'd1));
  endfunction

  function automatic logic [31:0] ref_encode(input int kind, input int op, input int rd,
                                             input int rs1, input int rs2,
                                             input logic [31:0] imm, output bit bad);
    logic [31:0] w;
    bit          shift;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    int          si;
    si = imm;
`endif
    bad   = 0;
    w     = 32'h13;
    shift = (op == 2) || (op == 6) || (op == 7);
    case (kind)
      0: if (op <= 9) w = fmt((op == 1 || op == 7) ? 32 : 0, rs2, rs1, alu_f3[op], rd, 'h33);
         else bad = 1;
      1: if (op > 9 || op == 1) bad = 1;
         else if (shift) w = fmt(op == 7 ? 32 : 0, bits(imm, 0, 5), rs1, alu_f3[op], rd, 'h13);
         else w = fmt(bits(imm, 5, 7), bits(imm, 0, 5), rs1, alu_f3[op], rd, 'h13);
      2: if (op inside {0, 1, 2, 4, 5}) w = fmt(bits(imm, 5, 7), bits(imm, 0, 5), rs1, op, rd, 'h03);
         else bad = 1;
      3: if (op inside {0, 1, 2}) w = fmt(bits(imm, 5, 7), rs2, rs1, op, bits(imm, 0, 5), 'h23);
         else bad = 1;
      4: if (op inside {0, 1, 4, 5, 6, 7})
           w = fmt(bits(imm, 12, 1) * 64 + bits(imm, 5, 6), rs2, rs1, op,
                   bits(imm, 1, 4) * 2 + bits(imm, 11, 1), 'h63);
         else bad = 1;
      5: w = (32'(bits(imm, 20, 1) * 524288 + bits(imm, 1, 10) * 512 + bits(imm, 11, 1) * 256
                  + bits(imm, 12, 8)) << 12) | fmt(0, 0, 0, 0, rd, 'h6f);
      6: w = fmt(bits(imm, 5, 7), bits(imm, 0, 5), rs1, 0, rd, 'h67);
      7: w = (imm & 32'hffff_f000) | fmt(0, 0, 0, 0, rd, 'h37);
      8: w = (imm & 32'hffff_f000) | fmt(0, 0, 0, 0, rd, 'h17);
      default: bad = 1;
    endcase
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    case (kind)
      1:       if (shift ? (imm > 31) : (si < -2048 || si > 2047)) bad = 1;
      2, 3, 6: if (si < -2048 || si > 2047) bad = 1;
      4:       if (si < -4096 || si > 4095 || imm[0]) bad = 1;
      5:       if (si < -1048576 || si > 1048575 || imm[0]) bad = 1;
      7, 8:    if ((imm & 32'hfff) != 0) bad = 1;
      default: ;
    endcase
`endif
    if (bad) w = 32'h13;
    return w;
  endfunction

  function automatic logic [31:0] rnd_s(input int n);
    return 32'($urandom_range(0, (1 << n) - 1)) - 32'(1 << (n - 1));
  endfunction

  task automatic start_load();
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    exp_addr = 0; exp_count = 0; exp_err = 0;
    chk("start_ready", bus.ready_o, 1);
    chk("start_count", bus.count_o, 0);
    chk("start_error", bus.error_o, 0);
    chk("start_done", bus.done_o, 0);
    chk("start_full", bus.full_o, 0);
  endtask

  task automatic send(input int kind, input int op, input int rd, input int rs1, input int rs2,
                      input logic [31:0] imm, input bit last, input int stall,
                      input logic [31:0] want, input bit want_bad);
    int waited;
    logic [31:0] exp_w;
    bus.kind_i = 4'(kind); bus.op_i = 4'(op);
    bus.rd_i = 5'(rd); bus.rs1_i = 5'(rs1); bus.rs2_i = 5'(rs2);
    bus.imm_i = imm; bus.last_i = last;
    bus.imem_ready_i = 1'b0;
    bus.valid_i = 1'b1;
    waited = 0;
    while (!bus.ready_o && waited < 20) begin
      tick();
      waited++;
    end
    if (!bus.ready_o) begin
      chk("accept_timeout", 0, 1);
      bus.valid_i = 1'b0;
      return;
    end
    exp_q.push_back(want);
    exp_err = exp_err | want_bad;
    tick();
    bus.valid_i = 1'b0;
    exp_w = exp_q[0];
    chk("we_latency", bus.imem_we_o, 1);
    chk("ready_in_write", bus.ready_o, 0);
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("stall_we", bus.imem_we_o, 1);
      chk("stall_data", bus.imem_data_o, exp_w);
      chk("stall_addr", bus.imem_addr_o, exp_addr);
    end
    exp_w = exp_q.pop_front();
    chk("data", bus.imem_data_o, exp_w);
    chk("addr", bus.imem_addr_o, exp_addr);
    chk("error", bus.error_o, exp_err);
    bus.imem_ready_i = 1'b1;
    tick();
    bus.imem_ready_i = 1'b0;
    exp_addr++;
    exp_count++;
    chk("count", bus.count_o, exp_count);
    chk("done", bus.done_o, last);
    chk("ready_after", bus.ready_o, !last);
    chk("state_after", bus.state_o, last ? S_DONE : S_ACCEPT);
  endtask

  initial begin
    int          n_acc;
    int          n_wr;
    bit          b;
    logic [31:0] w;

    bus.start_i = 0; bus.valid_i = 0; bus.kind_i = 0; bus.op_i = 0; bus.rd_i = 0;
    bus.rs1_i = 0; bus.rs2_i = 0; bus.imm_i = 0; bus.last_i = 0; bus.imem_ready_i = 0;
    bus_s.start_i = 0; bus_s.valid_i = 0; bus_s.kind_i = 0; bus_s.op_i = 0; bus_s.rd_i = 0;
    bus_s.rs1_i = 0; bus_s.rs2_i = 0; bus_s.imm_i = 0; bus_s.last_i = 0; bus_s.imem_ready_i = 0;

    // Reset state
    tick(); tick(); tick();
    chk("rst_we", bus.imem_we_o, 0);
    chk("rst_ready", bus.ready_o, 0);
    chk("rst_count", bus.count_o, 0);
    chk("rst_data", bus.imem_data_o, 0);
    rst = 1'b0;
    tick();
    chk("idle_state", bus.state_o, S_IDLE);
    chk("idle_done", bus.done_o, 0);

    // Valid in IDLE is not consumed
    bus.valid_i = 1'b1;
    tick(); tick();
    chk("idle_valid_ready", bus.ready_o, 0);
    chk("idle_valid_we", bus.imem_we_o, 0);
    bus.valid_i = 1'b0;

    // SUB x3, x1, x2 as a one-word program; Done holds afterwards
    start_load();
    send(KIND_R, ALU_SUB, 3, 1, 2, 32'd0, 1, 0, 32'h402081B3, 0);
    tick(); tick(); tick();
    chk("done_hold", bus.done_o, 1);
    chk("done_count", bus.count_o, 1);

    // ADDI then SW, with a Start pulse in ACCEPT that must be ignored
    start_load();
    send(KIND_I, ALU_ADD, 1, 0, 0, 32'd5, 0, 0, 32'h00500093, 0);
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    chk("start_in_accept_count", bus.count_o, 1);
    chk("start_in_accept_addr", bus.imem_addr_o, 1);
    send(KIND_S, SZ_W, 0, 1, 2, 32'd8, 1, 0, 32'h0020A423, 0);

    // LUI with three stalled cycles
    start_load();
    send(KIND_LUI, 0, 5, 0, 0, 32'h12345000, 1, 3, 32'h123452B7, 0);

    // BEQ with odd offset 3
    start_load();
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    send(KIND_B, CMP_EQ, 0, 1, 2, 32'd3, 1, 0, 32'h00000013, 1);
    tick();
    chk("beq_error_sticky", bus.error_o, 1);
`else
    send(KIND_B, CMP_EQ, 0, 1, 2, 32'd3, 1, 0, 32'h00208163, 0);
    tick();
    chk("beq_no_error", bus.error_o, 0);
`endif

    // Reset while a write is stalled
    start_load();
    send(KIND_I, ALU_ADD, 2, 0, 0, 32'd9, 0, 0, 32'h00900113, 0);
    bus.kind_i = 4'(KIND_I); bus.op_i = ALU_ADD; bus.imm_i = 32'd1; bus.last_i = 1'b1;
    bus.valid_i = 1'b1;
    tick();
    bus.valid_i = 1'b0;
    chk("rst_pre_we", bus.imem_we_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_we", bus.imem_we_o, 0);
    chk("rst_async_state", bus.state_o, S_IDLE);
    chk("rst_async_count", bus.count_o, 0);
    chk("rst_async_addr", bus.imem_addr_o, 0);
    chk("rst_async_data", bus.imem_data_o, 0);
    chk("rst_async_ready", bus.ready_o, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rst_release_state", bus.state_o, S_IDLE);
    chk("rst_release_we", bus.imem_we_o, 0);

    // Random program against the reference model
    start_load();
    for (int i = 0; i < 40; i++) begin
      int          k;
      int          o;
      int          rd;
      int          r1;
      int          r2;
      logic [31:0] im;
      k  = int'($urandom_range(0, 9));
      o  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
      rd = int'($urandom_range(0, 31));
      r1 = int'($urandom_range(0, 31));
      r2 = int'($urandom_range(0, 31));
      case (k)
        1:       im = (o == 2 || o == 6 || o == 7) ? 32'($urandom_range(0, 31)) : rnd_s(12);
        2, 3, 6: im = rnd_s(12);
        4:       im = rnd_s(13) & ~32'd1;
        5:       im = rnd_s(21) & ~32'd1;
        default: im = $urandom & 32'hffff_f000;
      endcase
      if ($urandom_range(0, 7) == 0) im = $urandom;
      w = ref_encode(k, o, rd, r1, r2, im, b);
      send(k, o, rd, r1, r2, im, i == 39, int'($urandom_range(0, 2)), w, b);
    end
    chk("rand_count", bus.count_o, 40);
    chk("rand_error", bus.error_o, exp_err);

    // ADDR_W=2 instance fills all four words and then refuses input
    w = ref_encode(1, 0, 1, 0, 0, 32'd7, b);
    bus_s.start_i = 1'b1;
    tick();
    bus_s.start_i = 1'b0;
    bus_s.kind_i = 4'(KIND_I); bus_s.op_i = ALU_ADD; bus_s.rd_i = 5'd1; bus_s.imm_i = 32'd7;
    bus_s.last_i = 1'b0; bus_s.valid_i = 1'b1; bus_s.imem_ready_i = 1'b1;
    n_acc = 0;
    n_wr  = 0;
    for (int c = 0; c < 16; c++) begin
      if (bus_s.ready_o && bus_s.valid_i) n_acc++;
      if (bus_s.imem_we_o && bus_s.imem_ready_i) begin
        chk("small_addr", bus_s.imem_addr_o, n_wr);
        chk("small_data", bus_s.imem_data_o, w);
        n_wr++;
      end
      tick();
    end
    bus_s.valid_i = 1'b0;
    bus_s.imem_ready_i = 1'b0;
    chk("small_writes", n_wr, 4);
    chk("small_accepts", n_acc, 4);
    chk("small_full", bus_s.full_o, 1);
    chk("small_done", bus_s.done_o, 1);
    chk("small_count", bus_s.count_o, 4);
    chk("small_ready", bus_s.ready_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
